// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the pipelined RV32 core: operand forwarding,
// load-use and branch stall/flush, mul/div execute-stage hold, and stall-cycle counting.
module hazard_ctrl #(
    parameter int MDIV_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             MulDivE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             mdiv_start,
    output logic             mdiv_done,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int CW = $clog2(MDIV_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MDIV_CYCLES - 2);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          lw_stall;
    logic          md_stall;

    // Memory stage holds the younger result, so it wins over write-back.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
            return 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign ForwardAE = fwd_sel(Rs1E);
    assign ForwardBE = fwd_sel(Rs2E);

    assign lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // Start is gated by reset so an asserted reset silences the unit immediately.
    assign mdiv_start = rst_n && (state == IDLE) && MulDivE;
    assign mdiv_done  = rst_n && (state == BUSY) && (cnt == '0);
    assign md_stall   = mdiv_start || (rst_n && (state == BUSY) && (cnt != '0));

    // A taken branch squashes the load-use consumer, so stalling it would be pointless.
    assign StallF = md_stall || (lw_stall && !PCSrcE);
    assign StallD = md_stall || (lw_stall && !PCSrcE);
    assign StallE = md_stall;
    assign FlushD = PCSrcE;
    assign FlushE = !md_stall && (lw_stall || PCSrcE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MulDivE) begin
                        state <= BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (StallF)
            stall_cycles <= sat_inc(stall_cycles);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected output vectors are queued as stimulus is
// applied and compared against the DUT at the following falling clock edge.
module tb_hazard_ctrl;

    localparam int MDC = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW, LoadE, PCSrcE, MulDivE;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, FlushD, FlushE, mdiv_start, mdiv_done;
    logic [CW-1:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_ctrl #(.MDIV_CYCLES(MDC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .MulDivE(MulDivE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE),
        .mdiv_start(mdiv_start), .mdiv_done(mdiv_done),
        .stall_cycles(stall_cycles)
    );

    // {fa[1:0], fb[1:0], sf, sd, se, fd, fe, start, done, stall_cycles[3:0]}
    logic [14:0] obs;
    assign obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
                  mdiv_start, mdiv_done, stall_cycles};

    // ctl = {sf, sd, se, fd, fe, start, done}
    localparam logic [6:0] C_IDLE  = 7'b0000000;
    localparam logic [6:0] C_START = 7'b1110010;
    localparam logic [6:0] C_MDST  = 7'b1110000;
    localparam logic [6:0] C_DONE  = 7'b0000001;
    localparam logic [6:0] C_LW    = 7'b1100100;
    localparam logic [6:0] C_FLUSH = 7'b0001100;

    logic [14:0] sb[$];
    logic [14:0] e;
    logic [3:0]  sc_model = 4'd0;
    int          checks = 0;
    int          failures = 0;

    function automatic logic [14:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic [6:0] ctl);
        return {fa, fb, ctl, sc_model};
    endfunction

    task automatic bump(input logic [6:0] ctl);
        if (ctl[6]) sc_model = (sc_model == 4'hF) ? sc_model : sc_model + 4'd1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0; MulDivE = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        MulDivE = 1; Rs1E = 5; RdM = 5; RegWriteM = 1;
        rst_n = 0;
        sc_model = 0;
        sb.push_back(mk(2'b10, 2'b00, C_IDLE));
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL reset_state: got %h expected %h", obs, e); end
        @(posedge clk); #1;
        rst_n = 1;
        clear_inputs();
        sb.push_back(mk(2'b00, 2'b00, C_IDLE));
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL reset_release: got %h expected %h", obs, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_forward();
        // Rs1E, Rs2E, RdM, RdW, RegWriteM, RegWriteW, fa, fb
        logic [4:0] t_rs1 [5] = '{5'd5, 5'd5, 5'd0, 5'd3, 5'd9};
        logic [4:0] t_rs2 [5] = '{5'd0, 5'd0, 5'd5, 5'd5, 5'd9};
        logic [4:0] t_rdm [5] = '{5'd5, 5'd0, 5'd0, 5'd5, 5'd9};
        logic [4:0] t_rdw [5] = '{5'd5, 5'd5, 5'd0, 5'd5, 5'd4};
        logic       t_wm  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       t_ww  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0] t_fa  [5] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b10};
        logic [1:0] t_fb  [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            Rs1E = t_rs1[i]; Rs2E = t_rs2[i]; RdM = t_rdm[i]; RdW = t_rdw[i];
            RegWriteM = t_wm[i]; RegWriteW = t_ww[i];
            sb.push_back(mk(t_fa[i], t_fb[i], C_IDLE));
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL forward_%0d: got %h expected %h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        logic       t_ld  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [4:0] t_rde [5] = '{5'd7, 5'd7, 5'd0, 5'd7, 5'd7};
        logic [4:0] t_rs1 [5] = '{5'd1, 5'd1, 5'd0, 5'd7, 5'd7};
        logic [4:0] t_rs2 [5] = '{5'd7, 5'd7, 5'd0, 5'd2, 5'd2};
        logic [6:0] t_ctl [5] = '{C_LW, C_IDLE, C_IDLE, C_LW, C_IDLE};
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            LoadE = t_ld[i]; RdE = t_rde[i]; Rs1D = t_rs1[i]; Rs2D = t_rs2[i];
            sb.push_back(mk(2'b00, 2'b00, t_ctl[i]));
            bump(t_ctl[i]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL load_use_%0d: got %h expected %h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_muldiv();
        // Cycle 1 also carries a load-use match that the mul/div hold must override.
        logic [6:0] t_ctl [5] = '{C_START, C_MDST, C_MDST, C_DONE, C_IDLE};
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            MulDivE = (i < 4);
            if (i == 1) begin LoadE = 1; RdE = 7; Rs1D = 7; end
            sb.push_back(mk(2'b00, 2'b00, t_ctl[i]));
            bump(t_ctl[i]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL muldiv_%0d: got %h expected %h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] sc_start;
        sc_start = sc_model;
        for (int i = 0; i < 9; i++) begin
            logic [6:0] ctl;
            clear_inputs();
            MulDivE = (i < 8);
            ctl = (i == 8) ? C_IDLE : ((i % 4) == 0) ? C_START : ((i % 4) == 3) ? C_DONE : C_MDST;
            sb.push_back(mk(2'b00, 2'b00, ctl));
            bump(ctl);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL b2b_%0d: got %h expected %h", i, obs, e); end
            @(posedge clk); #1;
        end
        checks++;
        if (stall_cycles !== sc_start + 4'd6) begin
            failures++;
            $display("FAIL b2b_stall_total: got %0d expected %0d", stall_cycles, sc_start + 4'd6);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            logic [6:0] ctl;
            clear_inputs();
            PCSrcE = (i < 2);
            if (i != 1) begin LoadE = 1; RdE = 7; Rs2D = 7; end
            ctl = (i < 2) ? C_FLUSH : C_LW;
            sb.push_back(mk(2'b00, 2'b00, ctl));
            bump(ctl);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL flush_%0d: got %h expected %h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_op();
        logic [6:0] t_ctl [5] = '{C_START, C_MDST, C_MDST, C_DONE, C_IDLE};
        clear_inputs();
        MulDivE = 1;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(2'b00, 2'b00, t_ctl[i]));
            bump(t_ctl[i]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL abort_pre_%0d: got %h expected %h", i, obs, e); end
            if (i == 0) begin @(posedge clk); #1; end
        end
        #2 rst_n = 0;
        sc_model = 0;
        sb.push_back(mk(2'b00, 2'b00, C_IDLE));
        #1;
        e = sb.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL abort_in_reset: got %h expected %h", obs, e); end
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            MulDivE = (i < 4);
            sb.push_back(mk(2'b00, 2'b00, t_ctl[i]));
            bump(t_ctl[i]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL abort_post_%0d: got %h expected %h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        clear_inputs();
        LoadE = 1; RdE = 3; Rs1D = 3;
        for (int i = 0; i < 20; i++) begin
            sb.push_back(mk(2'b00, 2'b00, C_LW));
            bump(C_LW);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL saturate_%0d: got %h expected %h", i, obs, e); end
            @(posedge clk); #1;
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (stall_cycles !== 4'hF) begin
            failures++;
            $display("FAIL saturate_final: got %0d expected 15", stall_cycles);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_muldiv();
        test_back_to_back();
        test_flush();
        test_reset_mid_op();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and sequencing controller for the pipelined RV32 core; drives the execute stage's forwarding selects.
- Generates stall and flush for the fetch, decode and execute pipeline registers.
- Sequences multi-cycle mul/div ops by holding the execute stage for a fixed latency.
- Counts stall cycles for performance monitoring.

Parameters:
- MDIV_CYCLES, 4, total cycles a mul/div instruction occupies the execute stage (legal range 2..16).
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Rs1D  in  5  decode-stage source register 1 address.
- Rs2D  in  5  decode-stage source register 2 address.
- Rs1E  in  5  execute-stage source register 1 address.
- Rs2E  in  5  execute-stage source register 2 address.
- RdE  in  5  execute-stage destination register.
- RdM  in  5  memory-stage destination register.
- RdW  in  5  write-back-stage destination register.
- RegWriteM  in  1  memory-stage instruction writes the register file.
- RegWriteW  in  1  write-back-stage instruction writes the register file.
- LoadE  in  1  execute-stage instruction is a load.
- PCSrcE  in  1  taken branch/jump in execute (the execute stage's mux1E).
- MulDivE  in  1  execute-stage instruction is a multi-cycle mul/div.
- ForwardAE  out  2  ALU input A forward select: 00 RD1E, 01 ResultW, 10 ALUResultM.
- ForwardBE  out  2  ALU input B forward select, same encoding.
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID register.
- StallE  out  1  hold ID/EX register.
- FlushD  out  1  clear IF/ID register.
- FlushE  out  1  clear ID/EX register (insert bubble).
- mdiv_start  out  1  one-cycle pulse: mul/div unit begins the op.
- mdiv_done  out  1  one-cycle pulse: mul/div result valid, op retires from execute this edge.
- stall_cycles  out  CNT_W  cycles in which StallF was high, saturating.

Behaviour:
Forwarding (combinational, per operand X in {1,2}):
- ForwardXE = 10 if RegWriteM and RdM != 0 and RdM == RsXE.
- Otherwise 01 if RegWriteW and RdW != 0 and RdW == RsXE.
- Otherwise 00.
- Memory stage has priority over write-back.

Load-use (combinational):
- lw_stall = LoadE and RdE != 0 and (RdE == Rs1D or RdE == Rs2D).
- lw_stall drives StallF=1, StallD=1, FlushE=1.

Mul/div FSM, states IDLE and BUSY, counter cnt of width $clog2(MDIV_CYCLES):
- IDLE with MulDivE=1: mdiv_start=1, md_stall=1; next state BUSY, cnt <= MDIV_CYCLES-2.
- BUSY with cnt != 0: md_stall=1, cnt decrements.
- BUSY with cnt == 0: md_stall=0, mdiv_done=1; next state IDLE. The instruction leaves execute on this edge.
- Net effect: execute occupancy is MDIV_CYCLES cycles, of which MDIV_CYCLES-1 are stalled.
- Back-to-back mul/div: the following op enters execute and restarts the FSM from IDLE in the next cycle, with no gap.
- md_stall drives StallF=1, StallD=1, StallE=1 and forces FlushE=0, overriding lw_stall.

Branch flush:
- PCSrcE drives FlushD=1 and FlushE=1.
- PCSrcE and md_stall never coincide (same execute slot). If PCSrcE and lw_stall are both high, flush wins: FlushD=1, FlushE=1, and StallF/StallD are forced 0.

Stall counter:
- Increments on each clock with StallF=1.
- Saturates at all-ones; never wraps.

Reset (rst_n=0, asynchronous):
- state=IDLE, cnt=0, stall_cycles=0.
- mdiv_start, mdiv_done and md_stall = 0.
- Forwarding and load-use outputs stay input-driven.
- Reset asserted mid mul/div aborts the op. After release the FSM is in IDLE; if MulDivE is still 1, a fresh mdiv_start is issued.

Test Plan:
- RdM=5, RegWriteM=1, Rs1E=5, and also RdW=5, RegWriteW=1 -> ForwardAE=10 (memory priority). Same setup with RdM=0 -> ForwardAE=01. With Rs2E=5, RdM=RdW=0 -> ForwardBE=00.
- LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly one cycle. RdE=0 -> no stall.
- MDIV_CYCLES=4, MulDivE=1 held -> mdiv_start in cycle 0; StallF/D/E high in cycles 0-2; mdiv_done and no stall in cycle 3; stall_cycles increases by 3.
- Two consecutive mul/div ops (MulDivE stays 1) -> two mdiv_start pulses 4 cycles apart; 6 stall cycles total.
- PCSrcE=1 together with load-use match -> FlushD=FlushE=1, StallF=StallD=0.
- rst_n pulsed low in BUSY cycle 1 -> outputs mdiv-idle immediately. After release with MulDivE=1 -> new mdiv_start, full 4-cycle sequence.
- CNT_W=4, StallF held 20 cycles -> stall_cycles saturates at 15.
